// File: rtl/room_thermal_model_if.sv
// ---------------------------------------------------------------------------
// room_thermal_model_if
//   Signal bundle between the air-conditioning controller and the room
//   thermal plant model.
//
//   Signals
//     heating      controller -> plant  heater command
//     cooling      controller -> plant  cooler command
//     temperature  plant -> controller  5-bit room temperature, unsigned
//     tick         plant -> controller  one-cycle pulse on each update edge
//     fault        plant -> controller  sticky heat+cool conflict flag
//
//   Modports
//     master  controller side (drives the commands)
//     slave   plant side (drives temperature/tick/fault)
// ---------------------------------------------------------------------------
interface room_thermal_model_if;
    logic       heating;
    logic       cooling;
    logic [4:0] temperature;
    logic       tick;
    logic       fault;

    modport master (
        output heating,
        output cooling,
        input  temperature,
        input  tick,
        input  fault
    );

    modport slave (
        input  heating,
        input  cooling,
        output temperature,
        output tick,
        output fault
    );
endinterface

// File: rtl/room_thermal_model.sv
// ---------------------------------------------------------------------------
// room_thermal_model
//   Closed-loop plant model for the air-conditioning controller. Every
//   TICK_DIV clock cycles it samples the heating/cooling commands and updates
//   the room temperature: heating raises it, cooling lowers it, idle drifts it
//   one degree toward AMBIENT every DRIFT_DIV idle ticks. Heating and cooling
//   together hold the temperature and set a sticky fault flag.
//
//   Ports
//     clk    in   system clock, all logic on posedge
//     rst_n  in   synchronous reset, active HIGH despite the name (1 = reset)
//     bus    slave modport of room_thermal_model_if
//              heating/cooling in, temperature/tick/fault out (all registered)
// ---------------------------------------------------------------------------
module room_thermal_model #(
    parameter int unsigned INIT_TEMP = 18,
    parameter int unsigned AMBIENT   = 16,
    parameter int unsigned TICK_DIV  = 4,
    parameter int unsigned HEAT_STEP = 1,
    parameter int unsigned COOL_STEP = 1,
    parameter int unsigned DRIFT_DIV = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    room_thermal_model_if.slave  bus
);

    localparam int unsigned PW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
    localparam int unsigned DW = (DRIFT_DIV > 1) ? $clog2(DRIFT_DIV) : 1;

    localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DRIFT_LAST = DW'(DRIFT_DIV - 1);
    localparam logic [4:0]    INIT_T     = 5'(INIT_TEMP);
    localparam logic [4:0]    AMB_T      = 5'(AMBIENT);
    localparam logic [5:0]    HEAT_S     = 6'(HEAT_STEP);
    localparam logic [5:0]    COOL_S     = 6'(COOL_STEP);

    // Encoding matches {heating, cooling} so the decode is a plain cast.
    typedef enum logic [1:0] {
        MODE_IDLE  = 2'b00,
        MODE_COOL  = 2'b01,
        MODE_HEAT  = 2'b10,
        MODE_FAULT = 2'b11
    } mode_e;

    logic [PW-1:0] prescale_q, prescale_d;
    logic [DW-1:0] drift_q,    drift_d;
    logic [4:0]    temp_q,     temp_d;
    logic          tick_q,     tick_d;
    logic          fault_q,    fault_d;
    mode_e         mode_q,     mode_d;

    mode_e         mode_in;
    logic [5:0]    heat_sum;
    logic [5:0]    cool_diff;
    logic [DW-1:0] drift_eff;

    assign mode_in   = mode_e'({bus.heating, bus.cooling});
    // Six-bit arithmetic: bit 5 flags overflow on the sum and borrow on the
    // difference, so both saturate instead of wrapping.
    assign heat_sum  = {1'b0, temp_q} + HEAT_S;
    assign cool_diff = {1'b0, temp_q} - COOL_S;
    // Entering IDLE from another mode always starts a fresh drift period.
    assign drift_eff = (mode_q == MODE_IDLE) ? drift_q : '0;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; a missing default here would infer a latch.
        prescale_d = (prescale_q == PRE_LAST) ? '0 : prescale_q + PW'(1);
        tick_d     = (prescale_q == PRE_LAST);
        drift_d    = drift_q;
        temp_d     = temp_q;
        fault_d    = fault_q;
        mode_d     = mode_q;

        if (tick_d) begin
            mode_d = mode_in;
            case (mode_in)
                MODE_HEAT: begin
                    temp_d  = heat_sum[5] ? 5'd31 : heat_sum[4:0];
                    drift_d = '0;
                end
                MODE_COOL: begin
                    temp_d  = cool_diff[5] ? 5'd0 : cool_diff[4:0];
                    drift_d = '0;
                end
                MODE_FAULT: begin
                    fault_d = 1'b1;
                    drift_d = '0;
                end
                MODE_IDLE: begin
                    if (drift_eff == DRIFT_LAST) begin
                        drift_d = '0;
                        if (temp_q > AMB_T) begin
                            temp_d = temp_q - 5'd1;
                        end else if (temp_q < AMB_T) begin
                            temp_d = temp_q + 5'd1;
                        end
                    end else begin
                        drift_d = drift_eff + DW'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst_n) begin
            // NOTE: reset is synchronous and clears every state register,
            // discarding any partial prescaler/drift count.
            prescale_q <= '0;
            drift_q    <= '0;
            temp_q     <= INIT_T;
            tick_q     <= 1'b0;
            fault_q    <= 1'b0;
            mode_q     <= MODE_IDLE;
        end else begin
            prescale_q <= prescale_d;
            drift_q    <= drift_d;
            temp_q     <= temp_d;
            tick_q     <= tick_d;
            fault_q    <= fault_d;
            mode_q     <= mode_d;
        end
    end

    assign bus.temperature = temp_q;
    assign bus.tick        = tick_q;
    assign bus.fault       = fault_q;

endmodule

// File: tb/tb_room_thermal_model.sv
// ---------------------------------------------------------------------------
// tb_room_thermal_model
//   Directed bench for room_thermal_model. dut0 uses the default parameters;
//   dut1 uses INIT_TEMP=4, 3-degree steps, TICK_DIV=1 and DRIFT_DIV=1 for the
//   large-step saturation cases. Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_room_thermal_model;

    logic clk = 1'b0;
    logic rst0;
    logic rst1;

    always #5 clk = ~clk;

    room_thermal_model_if bus0 ();
    room_thermal_model_if bus1 ();

    room_thermal_model #(
        .INIT_TEMP(18), .AMBIENT(16), .TICK_DIV(4),
        .HEAT_STEP(1),  .COOL_STEP(1), .DRIFT_DIV(4)
    ) dut0 (
        .clk   (clk),
        .rst_n (rst0),
        .bus   (bus0)
    );

    room_thermal_model #(
        .INIT_TEMP(4),  .AMBIENT(16), .TICK_DIV(1),
        .HEAT_STEP(3),  .COOL_STEP(3), .DRIFT_DIV(1)
    ) dut1 (
        .clk   (clk),
        .rst_n (rst1),
        .bus   (bus1)
    );

    typedef struct {
        logic       h;
        logic       c;
        int         ticks;
        logic [4:0] temp;
        logic       flt;
    } vec_t;

    typedef struct {
        logic       h;
        logic       c;
        logic [4:0] temp;
    } edge_t;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Waits for the next tick on dut0; returns how many edges it took.
    task automatic wait_tick0(output int cycles);
        cycles = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (bus0.tick === 1'b1) begin
                cycles = i;
                break;
            end
        end
        if (cycles == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL tick_timeout: got no tick, expected one within 12 cycles");
        end
    endtask

    task automatic reset0(input int hold, input string tag);
        int cyc;
        @(negedge clk);
        rst0         = 1'b1;
        bus0.heating = 1'b0;
        bus0.cooling = 1'b0;
        repeat (hold) @(negedge clk);
        rst0 = 1'b0;
        check({tag, "_temp"},  32'(bus0.temperature), 32'd18);
        check({tag, "_tick"},  32'(bus0.tick),        32'd0);
        check({tag, "_fault"}, 32'(bus0.fault),       32'd0);
        wait_tick0(cyc);
        check({tag, "_first_tick_cycles"}, 32'(cyc), 32'd4);
    endtask

    vec_t  vecs [23];
    edge_t edges[17];

    initial begin
        int cyc;
        int last;

        rst0 = 1'b1;
        rst1 = 1'b1;
        bus0.heating = 1'b0;
        bus0.cooling = 1'b0;
        bus1.heating = 1'b0;
        bus1.cooling = 1'b0;

        //            h     c     ticks temp   fault
        vecs[0]  = '{1'b1, 1'b0, 11, 5'd29, 1'b0}; // heat 18 -> 29
        vecs[1]  = '{1'b1, 1'b0, 1,  5'd30, 1'b0}; // heat saturation
        vecs[2]  = '{1'b1, 1'b0, 1,  5'd31, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1,  5'd31, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1,  5'd31, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1,  5'd30, 1'b0}; // cool
        vecs[6]  = '{1'b0, 1'b1, 16, 5'd14, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 3,  5'd14, 1'b0}; // idle below ambient
        vecs[8]  = '{1'b0, 1'b0, 1,  5'd15, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 4,  5'd16, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 4,  5'd16, 1'b0}; // at ambient: constant
        vecs[11] = '{1'b1, 1'b0, 2,  5'd18, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 3,  5'd18, 1'b0}; // idle above ambient
        vecs[13] = '{1'b0, 1'b0, 1,  5'd17, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 4,  5'd16, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 8,  5'd16, 1'b0};
        vecs[16] = '{1'b1, 1'b1, 1,  5'd16, 1'b1}; // conflict: hold, fault
        vecs[17] = '{1'b1, 1'b0, 1,  5'd17, 1'b1}; // still heats, fault sticky
        vecs[18] = '{1'b0, 1'b0, 2,  5'd17, 1'b1}; // partial drift count
        vecs[19] = '{1'b1, 1'b0, 1,  5'd18, 1'b1}; // heat clears drift count
        vecs[20] = '{1'b0, 1'b0, 3,  5'd18, 1'b1}; // full period needed again
        vecs[21] = '{1'b0, 1'b0, 1,  5'd17, 1'b1};
        vecs[22] = '{1'b0, 1'b1, 1,  5'd16, 1'b1};

        //             h     c     temp
        edges[0]  = '{1'b0, 1'b1, 5'd1};  // cool by 3 from 4
        edges[1]  = '{1'b0, 1'b1, 5'd0};  // saturates at 0
        edges[2]  = '{1'b0, 1'b1, 5'd0};
        edges[3]  = '{1'b1, 1'b0, 5'd3};
        edges[4]  = '{1'b1, 1'b0, 5'd6};
        edges[5]  = '{1'b0, 1'b0, 5'd7};  // drift every idle tick
        edges[6]  = '{1'b0, 1'b0, 5'd8};
        edges[7]  = '{1'b1, 1'b0, 5'd11};
        edges[8]  = '{1'b1, 1'b0, 5'd14};
        edges[9]  = '{1'b1, 1'b0, 5'd17};
        edges[10] = '{1'b1, 1'b0, 5'd20};
        edges[11] = '{1'b1, 1'b0, 5'd23};
        edges[12] = '{1'b1, 1'b0, 5'd26};
        edges[13] = '{1'b1, 1'b0, 5'd29};
        edges[14] = '{1'b1, 1'b0, 5'd31}; // 29+3 saturates, no wrap
        edges[15] = '{1'b1, 1'b0, 5'd31};
        edges[16] = '{1'b0, 1'b0, 5'd30};

        // Reset held 3 cycles; first tick exactly 4 cycles after release.
        reset0(3, "reset");

        for (int v = 0; v < 23; v++) begin
            @(negedge clk);
            bus0.heating = vecs[v].h;
            bus0.cooling = vecs[v].c;
            last = 0;
            for (int t = 0; t < vecs[v].ticks; t++) begin
                wait_tick0(cyc);
                last = cyc;
            end
            check($sformatf("vec%0d_temp", v),   32'(bus0.temperature), 32'(vecs[v].temp));
            check($sformatf("vec%0d_fault", v),  32'(bus0.fault),       32'(vecs[v].flt));
            check($sformatf("vec%0d_period", v), 32'(last),             32'd4);
        end

        // Heating pulsed only on the non-tick edges must be ignored.
        @(negedge clk);
        bus0.cooling = 1'b0;
        bus0.heating = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus0.heating = 1'b0;
        wait_tick0(cyc);
        check("glitch_temp",  32'(bus0.temperature), 32'd16);
        check("glitch_fault", 32'(bus0.fault),       32'd1);

        // Reset two cycles into a period: temp reloads, fault clears and the
        // prescaler restarts from zero.
        @(posedge clk);
        @(posedge clk);
        reset0(1, "midreset");

        // Large-step corner cases on dut1, which ticks every cycle.
        @(negedge clk);
        rst1 = 1'b0;
        for (int e = 0; e < 17; e++) begin
            bus1.heating = edges[e].h;
            bus1.cooling = edges[e].c;
            @(posedge clk);
            #1;
            check($sformatf("dut1_edge%0d_tick", e), 32'(bus1.tick),        32'd1);
            check($sformatf("dut1_edge%0d_temp", e), 32'(bus1.temperature), 32'(edges[e].temp));
            @(negedge clk);
        end
        check("dut1_fault", 32'(bus1.fault), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
